ram_byte_master: RTL and testbench

Initiator side of the byte-wide scratch RAM port: accepts 8/16/32-bit load and store requests from the engine-V core and turns each into a sequence of single-byte RAM accesses. RAM port contract: one-cycle registered read latency, write on clock edge when `ram_we` is high. Little-endian byte order, 15-bit byte addresses, sign/zero extension of loads. Sits between the core's load/store unit and the 32 KB RAM instance.

---
 rtl/ram_byte_master_pkg.sv | 34 +++
 rtl/ram_byte_master_if.sv | 30 +++
 rtl/ram_byte_master_load_extend.sv | 30 +++
 rtl/ram_byte_master.sv | 115 +++++++++++
 tb/tb_ram_byte_master.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_byte_master_pkg.sv
// Shared definitions for the byte-wide scratch RAM initiator.
//   - ADDR_W_DEFAULT : default byte address width (32 KB RAM)
//   - SIZE_B/H/W     : request size encodings (3 is treated as word)
//   - state_t        : sequencer states
//   - last_idx       : index of the final byte for a given size
//   - byte_lane      : extract little-endian byte i of a 32-bit word
package ram_master_pkg;

  localparam int ADDR_W_DEFAULT = 15;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ram_byte_master_if.sv
// Core-side load/store request/response bundle for ram_byte_master.
//   master : load/store unit (drives req_*, receives req_ready and rsp_*)
//   slave  : ram_byte_master (receives req_*, drives req_ready and rsp_*)
interface ram_byte_master_if
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_byte_master_load_extend.sv
// Load formatter: sign- or zero-extends gathered little-endian load data.
//   data        in  32 : gathered bytes, lane k = bits [8k+7:8k]
//   size        in  2  : SIZE_B / SIZE_H / word (2 or 3)
//   is_unsigned in  1  : 1 = zero-extend, 0 = sign-extend
//   rdata       out 32 : extended result (word passes through unchanged)
module ram_load_extend
  import ram_master_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = data[7:0];
  assign half_s = data[15:0];

  always_comb begin
    rdata = data;
    case (size)
      SIZE_B:  rdata = is_unsigned ? {24'h000000, data[7:0]} : 32'(byte_s);
      SIZE_H:  rdata = is_unsigned ? {16'h0000, data[15:0]} : 32'(half_s);
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/ram_byte_master.sv
// Byte-serialising initiator for the 8-bit scratch RAM port.
// Turns 8/16/32-bit loads and stores into 1/2/4 single-byte RAM accesses,
// little-endian, addresses wrapping modulo 2^ADDR_W.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : core request/response bundle (slave side)
//   ram_addr  : RAM byte address (registered)
//   ram_din   : RAM write byte (registered)
//   ram_we    : RAM write enable (registered)
//   ram_dout  : RAM read byte, valid one cycle after its address
module ram_byte_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ram_byte_master_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  state_t      state, state_n;
  logic [1:0]  k;
  logic [1:0]  k_prev;
  logic [1:0]  last;

  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] ext;

  assign last   = last_idx(size_q);
  assign k_prev = k - 2'd1;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (bus.req_valid) state_n = ST_ACCESS;
      ST_ACCESS: if (k == last)     state_n = we_q ? ST_RESP : ST_DRAIN;
      ST_DRAIN:  state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Byte counter and registered RAM port: the values for byte k are loaded
  // on the edge that enters its ACCESS cycle, so no req_* reaches ram_*
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= 2'd0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            k        <= 2'd0;
            ram_we   <= bus.req_we;
            ram_addr <= bus.req_addr;
            ram_din  <= bus.req_wdata[7:0];
          end
        end
        ST_ACCESS: begin
          if (k == last) begin
            ram_we <= 1'b0;
          end else begin
            k        <= k + 2'd1;
            ram_addr <= ram_addr + 1'b1;
            ram_din  <= byte_lane(wdata_q, k + 2'd1);
          end
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

  // Request latch and load gather. Read data lags its address by one
  // cycle, so ACCESS k captures byte k-1 and DRAIN captures the last byte.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req_valid) begin
      size_q  <= bus.req_size;
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      wdata_q <= bus.req_wdata;
    end
    if (state == ST_ACCESS && !we_q && k != 2'd0)
      data_q[{k_prev, 3'b000} +: 8] <= ram_dout;
    if (state == ST_DRAIN)
      data_q[{last, 3'b000} +: 8] <= ram_dout;
  end

  ram_load_extend u_extend (
    .data        (data_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (ext)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = (state == ST_RESP && !we_q) ? ext : 32'h0;

endmodule

// File: tb/tb_ram_byte_master.sv
// Scoreboard bench for ram_byte_master: a behavioural 32 KB RAM, a driver
// that pushes expected RAM writes and responses at handshake time, and a
// negedge monitor that pops and compares them.
module tb_ram_byte_master;
  import ram_master_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout = 8'h00;

  ram_byte_master_if #(.ADDR_W(AW)) bus ();

  ram_byte_master #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor write port for preloading
  logic [7:0]    mem [0:32767] = '{default: 8'h00};
  logic          bk_we   = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [7:0]    bk_data = 8'h00;

  always @(posedge clk) begin
    if (bk_we)       mem[bk_addr]  <= bk_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] rdata; int cyc; } rsp_exp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [7:0] din; } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];
  rsp_exp_t re;
  wr_exp_t  we_e;

  // Monitor: compare every response and every RAM write against the queues
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h at cycle %0d expected none", bus.rsp_rdata, cyc);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, re.rdata);
        chk("rsp_cycle", cyc, re.cyc);
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%04h din 0x%02h at cycle %0d expected none", ram_addr, ram_din, cyc);
      end else begin
        we_e = wr_q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(we_e.addr));
        chk("wr_din", 32'(ram_din), 32'(we_e.din));
        chk("wr_cycle", cyc, we_e.cyc);
      end
    end
  end

  function automatic int n_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 1;
      SIZE_H:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int latency(input logic we, input logic [1:0] size);
    return n_bytes(size) + (we ? 1 : 2);
  endfunction

  task automatic bk_write(input logic [AW-1:0] a, input logic [7:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    @(negedge clk);
    bk_we   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with req_valid still high, so back-to-back calls keep it asserted.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [31:0] exp,
                       output int hs);
    wr_exp_t  w;
    rsp_exp_t r;
    logic [AW-1:0] a;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    hs = -1;
    for (int t = 0; t < 100; t++) begin
      if (bus.req_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready 0 for 100 cycles expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    if (we) begin
      a = addr;
      for (int j = 0; j < n_bytes(size); j++) begin
        w.cyc  = hs + 1 + j;
        w.addr = a;
        w.din  = wdata[8*j +: 8];
        wr_q.push_back(w);
        a = a + 1'b1;
      end
    end
    r.rdata = exp;
    r.cyc   = hs + latency(we, size);
    rsp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input logic [31:0] exp);
    int hs;
    issue(we, addr, size, uns, wdata, exp, hs);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      if (rsp_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, hr;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = SIZE_B;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_din", 32'(ram_din), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    bk_write(15'h0200, 8'h80);
    bk_write(15'h0201, 8'h7F);
    bk_write(15'h0202, 8'h01);
    bk_write(15'h0203, 8'hFE);

    // we, addr, size, unsigned, wdata, expected rdata
    txn(1'b1, 15'h0100, SIZE_W, 1'b0, 32'h11223344, 32'h00000000);
    txn(1'b0, 15'h0200, SIZE_W, 1'b0, 32'h0,        32'hFE017F80);
    txn(1'b0, 15'h0200, SIZE_B, 1'b0, 32'h0,        32'hFFFFFF80);
    txn(1'b0, 15'h0200, SIZE_B, 1'b1, 32'h0,        32'h00000080);
    txn(1'b0, 15'h0201, SIZE_H, 1'b0, 32'h0,        32'h0000017F);
    txn(1'b0, 15'h0202, SIZE_H, 1'b0, 32'h0,        32'hFFFFFE01);
    txn(1'b0, 15'h0202, SIZE_H, 1'b1, 32'h0,        32'h0000FE01);
    txn(1'b0, 15'h0200, 2'd3,   1'b0, 32'h0,        32'hFE017F80);
    txn(1'b0, 15'h0100, SIZE_W, 1'b1, 32'h0,        32'h11223344);
    txn(1'b1, 15'h7FFE, SIZE_W, 1'b0, 32'hA1B2C3D4, 32'h00000000);
    txn(1'b0, 15'h7FFE, SIZE_W, 1'b0, 32'h0,        32'hA1B2C3D4);
    txn(1'b1, 15'h0400, SIZE_H, 1'b0, 32'h1234BEEF, 32'h00000000);
    txn(1'b1, 15'h0402, SIZE_B, 1'b0, 32'hFFFFFF66, 32'h00000000);
    txn(1'b0, 15'h0400, SIZE_W, 1'b0, 32'h0,        32'h0066BEEF);
    drain();
    chk("wrap_mem_0000", 32'(mem[0]), 32'h000000B2);
    chk("wrap_mem_0001", 32'(mem[1]), 32'h000000A1);

    // Back-to-back with req_valid held high
    issue(1'b1, 15'h0500, SIZE_B, 1'b0, 32'h00000077, 32'h0, h1);
    issue(1'b0, 15'h0500, SIZE_B, 1'b1, 32'h0, 32'h00000077, h2);
    bus.req_valid = 1'b0;
    chk("b2b_accept_cycle", h2, h1 + latency(1'b1, SIZE_B) + 1);
    drain();

    // Reset during cycle 2 of a word store
    bus.req_we       = 1'b1;
    bus.req_addr     = 15'h0300;
    bus.req_size     = SIZE_W;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'hAABBCCDD;
    bus.req_valid    = 1'b1;
    chk("rstop_ready", 32'(bus.req_ready), 32'h1);
    hr = cyc;
    we_e.cyc  = hr + 1;
    we_e.addr = 15'h0300;
    we_e.din  = 8'hDD;
    wr_q.push_back(we_e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rstop_ram_we_async", 32'(ram_we), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstop_ready_after", 32'(bus.req_ready), 32'h1);
    chk("rstop_no_rsp", 32'(bus.rsp_valid), 32'h0);
    repeat (8) @(negedge clk);
    chk("rstop_mem_0300", 32'(mem[15'h0300]), 32'h000000DD);
    chk("rstop_mem_0301", 32'(mem[15'h0301]), 32'h00000000);
    chk("rstop_mem_0302", 32'(mem[15'h0302]), 32'h00000000);
    chk("rstop_mem_0303", 32'(mem[15'h0303]), 32'h00000000);

    // Recovery after reset
    txn(1'b0, 15'h0300, SIZE_B, 1'b1, 32'h0, 32'h000000DD);
    drain();
    repeat (4) @(negedge clk);

    chk("rsp_queue_empty", rsp_q.size(), 32'h0);
    chk("wr_queue_empty", wr_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
